// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with optional parity check
//
// Receives LSB-first asynchronous serial frames: start, DATA_BITS data bits,
// optional parity bit, STOP_BITS stop bits. The line is resynchronised
// through two flops before any decision is made.
//
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and checker;
// without it o_parity_err is tied low and PARITY_ODD has no effect).
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_rx_serial   asynchronous serial input, idle high
//   o_rx_dv       one-cycle strobe per completed frame
//   o_rx_byte     received data, held until next strobe
//   o_parity_err  parity mismatch of last frame, held until next strobe
//   o_frame_err   a stop bit sampled low in last frame, held until next strobe
//   o_rx_active   high from confirmed start bit until return to idle

module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_serial,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_rx_active
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          P_ODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    state_t               r_state, w_state;
    logic                 r_sync0, r_sync1;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [3:0]           r_bit_idx, w_bit_idx;
    logic                 r_stop_idx, w_stop_idx;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_ferr, w_ferr;
    logic                 r_dv, w_dv;
    logic [DATA_BITS-1:0] r_byte, w_byte;
    logic                 r_ferr_out, w_ferr_out;
`ifdef UART_RX_PARITY_EN
    logic                 r_perr, w_perr;
    logic                 r_perr_out, w_perr_out;
`endif
    logic                 w_rx;

    assign w_rx = r_sync1;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit_idx  = r_bit_idx;
        w_stop_idx = r_stop_idx;
        w_shift    = r_shift;
        w_ferr     = r_ferr;
        w_dv       = 1'b0;
        w_byte     = r_byte;
        w_ferr_out = r_ferr_out;
`ifdef UART_RX_PARITY_EN
        w_perr     = r_perr;
        w_perr_out = r_perr_out;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt      = '0;
                w_bit_idx  = 4'd0;
                w_stop_idx = 1'b0;
                w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
                w_perr     = 1'b0;
`endif
                if (!w_rx) begin
                    w_state = S_START;
                end
            end
            S_START: begin
                // Re-check the line mid start bit to reject glitches.
                if (r_cnt == C_HALF) begin
                    w_cnt   = '0;
                    w_state = w_rx ? S_IDLE : S_DATA;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt   = '0;
                    w_shift = {w_rx, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state = S_PARITY;
`else
                        w_state = S_STOP;
`endif
                    end else begin
                        w_bit_idx = r_bit_idx + 4'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == C_LAST) begin
                    w_cnt   = '0;
                    w_perr  = (^r_shift) ^ w_rx ^ P_ODD;
                    w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt = '0;
                    if (!w_rx) begin
                        w_ferr = 1'b1;
                    end
                    if (r_stop_idx == STOP_LAST) begin
                        w_state    = S_CLEANUP;
                        w_dv       = 1'b1;
                        w_byte     = r_shift;
                        w_ferr_out = r_ferr | ~w_rx;
`ifdef UART_RX_PARITY_EN
                        w_perr_out = r_perr;
`endif
                    end else begin
                        w_stop_idx = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_CLEANUP: begin
                // Wait for an idle line so a break cannot look like a new start.
                if (w_rx) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_sync0    <= 1'b1;
            r_sync1    <= 1'b1;
            r_cnt      <= '0;
            r_bit_idx  <= 4'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_dv       <= 1'b0;
            r_byte     <= '0;
            r_ferr_out <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
            r_perr_out <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_sync0    <= i_rx_serial;
            r_sync1    <= r_sync0;
            r_cnt      <= w_cnt;
            r_bit_idx  <= w_bit_idx;
            r_stop_idx <= w_stop_idx;
            r_shift    <= w_shift;
            r_ferr     <= w_ferr;
            r_dv       <= w_dv;
            r_byte     <= w_byte;
            r_ferr_out <= w_ferr_out;
`ifdef UART_RX_PARITY_EN
            r_perr     <= w_perr;
            r_perr_out <= w_perr_out;
`endif
        end
    end

    assign o_rx_dv     = r_dv;
    assign o_rx_byte   = r_byte;
    assign o_frame_err = r_ferr_out;
    assign o_rx_active = (r_state != S_IDLE) && (r_state != S_START);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_perr_out;
`else
    // Parity sense has no effect without the checker.
    assign o_parity_err = P_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1 @217 and 7-bit/2-stop @16)

module tb_uart_rx_cfg;

    localparam int C1 = 217;
    localparam int C2 = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    typedef struct {
        int data;
        int perr;
        int ferr;
        int lo;
        int hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx1, rx2;
    logic       dv1, perr1, ferr1, act1;
    logic [7:0] byte1;
    logic       dv2, perr2, ferr2, act2;
    logic [6:0] byte2;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   last_d[2];
    int   last_p[2];
    int   last_f[2];
    int   ndv[2];

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(C1), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx1), .o_rx_dv(dv1), .o_rx_byte(byte1),
        .o_parity_err(perr1), .o_frame_err(ferr1), .o_rx_active(act1)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(C2), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx2), .o_rx_dv(dv2), .o_rx_byte(byte2),
        .o_parity_err(perr2), .o_frame_err(ferr2), .o_rx_active(act2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic drive(input int w, input logic v, input int n);
        if (w == 0) rx1 = v;
        else        rx2 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a frame is start + nb data + parity(optional) + ns stops; the
    // strobe must fall inside the last stop bit, after its midpoint.
    task automatic send(input int w, input int d, input int pbit_in, input int stopv);
        int   nb, ns, ck, odd, dm, pbit, nbits;
        exp_t e;
        nb  = (w == 0) ? 8 : 7;
        ns  = (w == 0) ? 1 : 2;
        ck  = (w == 0) ? C1 : C2;
        odd = (w == 0) ? 0 : 1;
        dm  = d & ((1 << nb) - 1);
        pbit = (pbit_in < 0) ? ((^dm) ^ odd) : pbit_in;
        nbits  = 1 + nb + PEN + ns;
        e.data = dm;
        e.perr = (PEN != 0) ? ((^dm) ^ (pbit & 1) ^ odd) : 0;
        e.ferr = (stopv == 0) ? 1 : 0;
        e.lo   = cyc + (nbits - 1) * ck + ck / 2;
        e.hi   = cyc + nbits * ck;
        if (w == 0) q1.push_back(e);
        else        q2.push_back(e);
        drive(w, 1'b0, ck);
        for (int i = 0; i < nb; i++) drive(w, ((dm >> i) & 1) != 0, ck);
        if (PEN != 0) drive(w, (pbit & 1) != 0, ck);
        for (int i = 0; i < ns; i++) drive(w, stopv != 0, ck);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (dv1) begin
                if (q1.size() == 0) chk("u1_unexpected_strobe", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("u1_data", int'(byte1), e.data);
                    chk("u1_perr", int'(perr1), e.perr);
                    chk("u1_ferr", int'(ferr1), e.ferr);
                    chk("u1_strobe_time", int'(cyc >= e.lo && cyc <= e.hi), 1);
                    last_d[0] = e.data; last_p[0] = e.perr; last_f[0] = e.ferr;
                    ndv[0]++;
                end
            end else begin
                chk("u1_hold_data", int'(byte1), last_d[0]);
                chk("u1_hold_perr", int'(perr1), last_p[0]);
                chk("u1_hold_ferr", int'(ferr1), last_f[0]);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (dv2) begin
                if (q2.size() == 0) chk("u2_unexpected_strobe", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("u2_data", int'(byte2), e.data);
                    chk("u2_perr", int'(perr2), e.perr);
                    chk("u2_ferr", int'(ferr2), e.ferr);
                    chk("u2_strobe_time", int'(cyc >= e.lo && cyc <= e.hi), 1);
                    last_d[1] = e.data; last_p[1] = e.perr; last_f[1] = e.ferr;
                    ndv[1]++;
                end
            end else begin
                chk("u2_hold_data", int'(byte2), last_d[1]);
                chk("u2_hold_perr", int'(perr2), last_p[1]);
                chk("u2_hold_ferr", int'(ferr2), last_f[1]);
            end
        end
    end

    initial begin
        int hi_cnt;
        for (int i = 0; i < 2; i++) begin
            last_d[i] = 0; last_p[i] = 0; last_f[i] = 0; ndv[i] = 0;
        end
        rst_n = 1'b0;
        rx1   = 1'b1;
        rx2   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_dv", int'(dv1), 0);
        chk("rst_byte", int'(byte1), 0);
        chk("rst_perr", int'(perr1), 0);
        chk("rst_ferr", int'(ferr1), 0);
        chk("rst_active", int'(act1), 0);
        chk("rst_u2_byte", int'(byte2), 0);
        rst_n = 1'b1;
        drive(0, 1'b1, 20);

        // Plain 8N1 frame.
        send(0, 'h3F, -1, 1);
        drive(0, 1'b1, C1);
        chk("lit_3f_byte", int'(byte1), 'h3F);
        chk("lit_3f_perr", int'(perr1), 0);
        chk("lit_3f_ferr", int'(ferr1), 0);
        chk("lit_idle_active", int'(act1), 0);

        // Deliberately wrong then correct even parity bit.
        send(0, 'h3F, 1, 1);
        drive(0, 1'b1, C1);
        chk("lit_par_bad", int'(perr1), PEN);
        send(0, 'h3F, 0, 1);
        drive(0, 1'b1, C1);
        chk("lit_par_good", int'(perr1), 0);

        send(0, 'h00, -1, 1);
        send(0, 'hFF, -1, 1);
        send(0, 'h81, -1, 1);
        drive(0, 1'b1, C1);
        chk("lit_81_byte", int'(byte1), 'h81);

        // Zero stop bit followed by a 20-bit break.
        send(0, 'hA5, -1, 0);
        drive(0, 1'b0, C1 * 10);
        chk("break_active", int'(act1), 1);
        drive(0, 1'b0, C1 * 10);
        chk("break_one_strobe", ndv[0], 7);
        drive(0, 1'b1, C1 * 2);
        chk("lit_a5_byte", int'(byte1), 'hA5);
        chk("lit_a5_ferr", int'(ferr1), 1);
        chk("break_release_active", int'(act1), 0);

        // 50-clock glitch on idle line.
        hi_cnt = 0;
        rx1 = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (act1) hi_cnt++;
        end
        @(posedge clk); #1;
        rx1 = 1'b1;
        repeat (C1 * 2) begin
            @(negedge clk);
            if (act1) hi_cnt++;
        end
        @(posedge clk); #1;
        chk("glitch_active", hi_cnt, 0);
        chk("glitch_no_strobe", ndv[0], 7);

        // Reset during data bit 3 of 0x55, then a clean 0xC3.
        drive(0, 1'b0, C1);
        drive(0, 1'b1, C1);
        drive(0, 1'b0, C1);
        drive(0, 1'b1, C1);
        drive(0, 1'b0, C1 / 2);
        chk("mid_frame_active", int'(act1), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rx1   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            last_d[i] = 0; last_p[i] = 0; last_f[i] = 0;
        end
        chk("mrst_byte", int'(byte1), 0);
        chk("mrst_ferr", int'(ferr1), 0);
        chk("mrst_active", int'(act1), 0);
        drive(0, 1'b1, C1 * 3);
        send(0, 'hC3, -1, 1);
        drive(0, 1'b1, C1);
        chk("lit_c3_byte", int'(byte1), 'hC3);
        chk("u1_total_strobes", ndv[0], 8);

        // 7-bit, 2-stop instance: back-to-back frames.
        send(1, 'h55, -1, 1);
        send(1, 'h2A, -1, 1);
        drive(1, 1'b1, C2 * 3);
        chk("b2b_strobes", ndv[1], 2);
        chk("lit_2a_byte", int'(byte2), 'h2A);
        chk("lit_2a_ferr", int'(ferr2), 0);
        send(1, 'h7F, -1, 1);
        send(1, 'h00, -1, 0);
        drive(1, 1'b1, C2 * 3);
        chk("lit_u2_ferr", int'(ferr2), 1);
        chk("u2_total_strobes", ndv[1], 4);

        chk("u1_queue_drained", q1.size(), 0);
        chk("u2_queue_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
